// File: rtl/task_worker.sv
// task_worker: runs one job of `len` cycles at a time, pulses done on completion
// and keeps a wrapping completed-job counter plus a sticky overrun flag.
module task_worker (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [7:0] count,
  output logic [7:0] jobs,
  output logic       err_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] target_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        // abort outranks completion when both land on the same edge
        if (abort) begin
          state_d = IDLE;
        end else if (count == target_q - 8'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= 8'd0;
      count       <= 8'd0;
      jobs        <= 8'd0;
      err_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            target_q <= len;
            count    <= 8'd0;
          end
        end
        RUN: begin
          if (abort) begin
            count <= 8'd0;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: begin
        end
      endcase
      if (state_d == DONE && state_q != DONE) begin
        jobs <= jobs + 8'd1;
      end
      if (start && state_q != IDLE) begin
        err_overrun <= 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_task_worker.sv
// Self-checking bench for task_worker: job-level reference model compared every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_task_worker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] count;
  logic [7:0] jobs;
  logic       err_overrun;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: a job is "active" from acceptance until its done cycle ends;
  // elapsed cycles are counted until they reach the requested length.
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_err    = 1'b0;
  bit         cmp_en   = 1'b0;
  int         m_count  = 0;
  int         m_len    = 0;
  logic [7:0] m_jobs   = 8'd0;

  task_worker dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .jobs        (jobs),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  task checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task modelStep();
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_count  = 0;
      m_jobs   = 8'd0;
      m_err    = 1'b0;
      cmp_en   = 1'b1;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_len    = int'(len);
        m_count  = 0;
        if (m_len == 0) begin
          m_done = 1'b1;
          m_jobs = m_jobs + 8'd1;
        end
      end
    end else if (m_done) begin
      if (start) m_err = 1'b1;
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      if (start) m_err = 1'b1;
      if (abort) begin
        m_active = 1'b0;
        m_count  = 0;
      end else begin
        m_count = m_count + 1;
        if (m_count == m_len) begin
          m_done = 1'b1;
          m_jobs = m_jobs + 8'd1;
        end
      end
    end
  endtask

  task tick();
    @(posedge clk);
    cycle++;
    modelStep();
    @(negedge clk);
    if (cmp_en) begin
      checkOutput("busy", 8'(busy), 8'(m_active));
      checkOutput("done", 8'(done), 8'(m_done));
      checkOutput("count", count, 8'(m_count));
      checkOutput("jobs", jobs, m_jobs);
      checkOutput("err_overrun", 8'(err_overrun), 8'(m_err));
    end
  endtask

  task applyStimulus(input bit s, input logic [7:0] l, input bit a, input bit r);
    start = s;
    len   = l;
    abort = a;
    reset = r;
    tick();
  endtask

  initial begin
    int busy_cycles;
    int done_at;
    int done_cnt;
    int n;
    int k;
    start = 1'b0;
    len   = 8'd0;
    abort = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b1);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    checkOutput("rst_done", 8'(done), 8'd0);
    checkOutput("rst_count", count, 8'd0);
    checkOutput("rst_jobs", jobs, 8'd0);
    checkOutput("rst_err", 8'(err_overrun), 8'd0);

    // Nominal len=5; len wiggles afterwards and must not matter
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
    busy_cycles = 0;
    done_at     = 0;
    for (int c = 1; c <= 6; c++) begin
      busy_cycles += int'(busy);
      if (done) done_at = c;
      if (c <= 5) checkOutput($sformatf("nom_count%0d", c), count, 8'(c - 1));
      applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0);
    end
    checkOutput("nom_busy_cycles", 8'(busy_cycles), 8'd6);
    checkOutput("nom_done_at", 8'(done_at), 8'd6);
    checkOutput("nom_idle_after", 8'(busy), 8'd0);
    checkOutput("nom_jobs", jobs, 8'd1);

    // Zero length
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    checkOutput("zero_done", 8'(done), 8'd1);
    checkOutput("zero_busy", 8'(busy), 8'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("zero_idle", 8'(busy), 8'd0);
    checkOutput("zero_jobs", jobs, 8'd2);

    // Overrun: second start four edges after the first
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'd10, 1'b0, 1'b0);
    checkOutput("ovr_err_before", 8'(err_overrun), 8'd0);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    checkOutput("ovr_err_set", 8'(err_overrun), 8'd1);
    done_cnt = 0;
    done_at  = 0;
    k        = 5;
    while (busy && k < 30) begin
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      applyStimulus(1'b0, 8'd3, 1'b0, 1'b0);
      k++;
    end
    checkOutput("ovr_idle", 8'(busy), 8'd0);
    checkOutput("ovr_done_cnt", 8'(done_cnt), 8'd1);
    checkOutput("ovr_done_at", 8'(done_at), 8'd11);
    checkOutput("ovr_err_sticky", 8'(err_overrun), 8'd1);
    checkOutput("ovr_jobs", jobs, 8'd3);

    // Abort at count=7, then a len=2 job
    applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
    n = 0;
    while (count != 8'd7 && n < 30) begin
      applyStimulus(1'b0, 8'd20, 1'b0, 1'b0);
      n++;
    end
    checkOutput("abt_reach7", count, 8'd7);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("abt_busy", 8'(busy), 8'd0);
    checkOutput("abt_done", 8'(done), 8'd0);
    checkOutput("abt_count", count, 8'd0);
    checkOutput("abt_jobs", jobs, 8'd3);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
    done_cnt = 0;
    n        = 0;
    while (busy && n < 10) begin
      done_cnt += int'(done);
      applyStimulus(1'b0, 8'd2, 1'b0, 1'b0);
      n++;
    end
    checkOutput("abt_next_done", 8'(done_cnt), 8'd1);
    checkOutput("abt_next_jobs", jobs, 8'd4);

    // Reset mid-job, overriding start and abort
    applyStimulus(1'b1, 8'd50, 1'b0, 1'b0);
    n = 0;
    while (count != 8'd30 && n < 60) begin
      applyStimulus(1'b0, 8'd50, 1'b0, 1'b0);
      n++;
    end
    checkOutput("mid_reach30", count, 8'd30);
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b1);
    checkOutput("mid_busy", 8'(busy), 8'd0);
    checkOutput("mid_count", count, 8'd0);
    checkOutput("mid_jobs", jobs, 8'd0);
    checkOutput("mid_err", 8'(err_overrun), 8'd0);
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      done_cnt += int'(done);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    end
    checkOutput("mid_no_done", 8'(done_cnt), 8'd0);

    // 256 back-to-back len=1 jobs wrap the job counter
    done_cnt = 0;
    for (int j = 0; j < 256; j++) begin
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
      n = 0;
      while (busy && n < 10) begin
        done_cnt += int'(done);
        applyStimulus(1'b0, 8'd1, 1'b0, 1'b0);
        n++;
      end
    end
    checkOutput("wrap_dones", 8'(done_cnt), 8'd0);
    checkOutput("wrap_jobs", jobs, 8'd0);
    checkOutput("wrap_err", 8'(err_overrun), 8'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) == 0,
                    ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 14)),
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/task_worker.md
TASK_WORKER -- requirements
Module: task_worker

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and reset, with all state updated on the rising edge of clk only.
REQ-002 The port list SHALL be, in order:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  job request pulse from the upstream sequencer (its start_a/b/c)
- len  input  8  job length in cycles, sampled with start
- abort  input  1  cancel the running job
- busy  output  1  high while a job is accepted and not yet retired
- done  output  1  one-cycle completion pulse to the sequencer (its done_a/b/c)
- count  output  8  cycles elapsed in the current job
- jobs  output  8  completed-job counter
- err_overrun  output  1  sticky flag: start received while busy

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN and DONE. All outputs SHALL be Moore outputs, registered or decoded from state only.
REQ-004 In IDLE with start=1 at edge T0, the block SHALL latch len into an internal target and clear count to 0.
- If len=0, the next state SHALL be DONE.
- Otherwise, the next state SHALL be RUN.
REQ-005 In RUN, count SHALL increment by 1 per edge; at the edge where count==target-1, the state SHALL go to DONE.
- Net effect: done is high in the cycle after edge T0+len, for any len in 0..255.
REQ-006 DONE SHALL last exactly one cycle and return to IDLE unconditionally.
- done SHALL be 1 only in DONE.
- On DONE entry, jobs SHALL increment by 1, wrapping 255->0.
REQ-007 busy SHALL be 1 whenever the state is not IDLE.
REQ-008 start while in RUN or DONE SHALL be ignored for sequencing: target, count and state are unaffected, and err_overrun SHALL set and stay 1 until reset.
REQ-009 abort=1 in RUN SHALL force IDLE on the next edge.
- No done pulse, jobs unchanged, count cleared to 0.
- abort SHALL take priority over completion on the same edge.
REQ-010 abort in IDLE or DONE SHALL have no effect.
- DONE still completes normally, with the done pulse and the jobs increment.
- abort together with start in IDLE: start wins and the job is accepted.
REQ-011 count SHALL hold its final value in DONE and IDLE until the next accepted start or abort.
REQ-012 len SHALL be sampled only on the accepting edge; later changes to len SHALL NOT affect the running job.

Reset
REQ-013 With reset=1 at an edge, the block SHALL go to IDLE and set busy=0, done=0, count=0, jobs=0, err_overrun=0.
REQ-014 Reset SHALL override start and abort in the same cycle, and reset mid-RUN SHALL produce no done pulse.
REQ-015 The first job SHALL be accepted on the first edge after reset deasserts, given start=1.

Verification
REQ-016 Nominal: reset 1 cycle, then start=1 with len=5 for 1 cycle.
- busy=1 for 6 cycles; done=1 exactly in the 6th cycle after the start edge.
- count sequence 0,1,2,3,4; jobs=1.
REQ-017 Zero length: start with len=0.
- done=1 in the cycle immediately after the start edge, busy=1 for 1 cycle, jobs increments.
REQ-018 Overrun: start with len=10, second start (len=3) 4 cycles later.
- err_overrun=1 from the next cycle and sticky.
- The job still finishes after 10 cycles, with exactly one done pulse.
REQ-019 Abort: start with len=20, abort at count=7.
- IDLE next cycle, no done pulse, jobs unchanged, count=0.
- A following start with len=2 completes normally.
REQ-020 Reset mid-job: start with len=50, reset at count=30.
- All outputs reach their reset values and no done pulse appears over the next 60 cycles.
REQ-021 Wrap: run 256 back-to-back jobs with len=1, start issued each time busy falls.
- jobs reads 0 after the 256th done; err_overrun stays 0.
